// File: rtl/boreal_pkg.sv
// Shared constants and FSM encoding for the biquad coefficient loader.
package boreal_pkg;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  localparam int COEFS_PER_STAGE = 5;

  localparam logic [15:0] Q15_ONE = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/boreal_coeff_shadow.sv
// Shadow coefficient bank: one write port, one read port,
// resets every stage to an identity (pass-through) biquad.
module boreal_coeff_shadow
  import boreal_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int COEF_W     = 16,
  parameter int SW         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SW-1:0]     wr_stage,
  input  logic [2:0]        wr_coef,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [SW-1:0]     rd_stage,
  input  logic [2:0]        rd_coef,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem_q [NUM_STAGES][COEFS_PER_STAGE];
  logic [COEF_W-1:0] mem_d [NUM_STAGES][COEFS_PER_STAGE];

  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int c = 0; c < COEFS_PER_STAGE; c++) begin
        if (we && wr_stage == SW'(s) && wr_coef == 3'(c)) begin
          mem_d[s][c] = wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int c = 0; c < COEFS_PER_STAGE; c++) begin
        if (rd_stage == SW'(s) && rd_coef == 3'(c)) begin
          rd_data = mem_q[s][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        for (int c = 0; c < COEFS_PER_STAGE; c++) begin
          mem_q[s][c] <= (c == 0) ? COEF_W'(Q15_ONE) : '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/boreal_biquad_coeff_loader.sv
// Pushes the shadow coefficient bank into a biquad cascade,
// starting only on a sample boundary.
module boreal_biquad_coeff_loader
  import boreal_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int COEF_W     = 16,
  parameter int SW         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW-1:0]         host_stage,
  input  logic [2:0]            host_coef,
  input  logic [COEF_W-1:0]     host_din,
  input  logic                  host_we,
  input  logic                  commit,
  input  logic                  err_clr,
  input  logic                  sample_valid,
  output logic [2:0]            reg_addr,
  output logic [COEF_W-1:0]     reg_din,
  output logic                  reg_we,
  output logic [NUM_STAGES-1:0] stage_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overlap,
  output logic                  err_wr_busy
);

  state_e state_q, state_d;
  logic [SW-1:0] st_q, st_d;
  logic [2:0] cf_q, cf_d;
  logic pend_q, pend_d;
  logic load;
  logic last_wr;
  logic busy_int;

  logic [2:0] reg_addr_q, reg_addr_d;
  logic [COEF_W-1:0] reg_din_q, reg_din_d;
  logic reg_we_q, reg_we_d;
  logic [NUM_STAGES-1:0] sel_q, sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovl_q, ovl_d;
  logic wrb_q, wrb_d;

  logic sh_we;
  logic [COEF_W-1:0] rd_data;

  assign busy_int = (state_q != ST_IDLE);
  assign last_wr  = (st_q == SW'(NUM_STAGES - 1)) && (cf_q == COEF_A2);

  assign sh_we = host_we && !busy_int
              && (32'(host_stage) < NUM_STAGES)
              && (host_coef <= COEF_A2);

  boreal_coeff_shadow #(
    .NUM_STAGES (NUM_STAGES),
    .COEF_W     (COEF_W),
    .SW         (SW)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (sh_we),
    .wr_stage (host_stage),
    .wr_coef  (host_coef),
    .wr_data  (host_din),
    .rd_stage (st_d),
    .rd_coef  (cf_d),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cf_d    = cf_q;
    pend_d  = pend_q;
    load    = 1'b0;
    if (busy_int && commit) pend_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (sample_valid) begin
          state_d = ST_WRITE;
          st_d    = '0;
          cf_d    = COEF_B0;
          load    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (last_wr) begin
          state_d = ST_DONE;
        end else begin
          load = 1'b1;
          if (cf_q == COEF_A2) begin
            cf_d = COEF_B0;
            st_d = st_q + SW'(1);
          end else begin
            cf_d = cf_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        // a commit landing on the DONE cycle itself is not lost
        pend_d  = 1'b0;
        state_d = (pend_q || commit) ? ST_WAIT_SYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_we_d   = load;
    sel_d      = '0;
    reg_addr_d = reg_addr_q;
    reg_din_d  = reg_din_q;
    if (load) begin
      reg_addr_d = cf_d;
      reg_din_d  = rd_data;
      for (int i = 0; i < NUM_STAGES; i++) begin
        sel_d[i] = (st_d == SW'(i));
      end
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
    ovl_d  = ((state_q == ST_WRITE) && sample_valid)
           | (ovl_q & ~err_clr);
    wrb_d  = (busy_int && host_we) | (wrb_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      st_q       <= '0;
      cf_q       <= '0;
      pend_q     <= 1'b0;
      reg_addr_q <= '0;
      reg_din_q  <= '0;
      reg_we_q   <= 1'b0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovl_q      <= 1'b0;
      wrb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      cf_q       <= cf_d;
      pend_q     <= pend_d;
      reg_addr_q <= reg_addr_d;
      reg_din_q  <= reg_din_d;
      reg_we_q   <= reg_we_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovl_q      <= ovl_d;
      wrb_q      <= wrb_d;
    end
  end

  assign reg_addr    = reg_addr_q;
  assign reg_din     = reg_din_q;
  assign reg_we      = reg_we_q;
  assign stage_sel   = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_overlap = ovl_q;
  assign err_wr_busy = wrb_q;

endmodule

// File: tb/tb_boreal_biquad_coeff_loader.sv
// Randomized bench for the coefficient loader against
// an array model of the shadow bank.
module tb_boreal_biquad_coeff_loader;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int SW = 3;
  localparam int NW = 5 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] host_stage = '0;
  logic [2:0]    host_coef = '0;
  logic [CW-1:0] host_din = '0;
  logic          host_we = 1'b0;
  logic          commit = 1'b0;
  logic          err_clr = 1'b0;
  logic          sample_valid = 1'b0;
  logic [2:0]    reg_addr;
  logic [CW-1:0] reg_din;
  logic          reg_we;
  logic [N-1:0]  stage_sel;
  logic          busy;
  logic          done;
  logic          err_overlap;
  logic          err_wr_busy;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] mdl [N][5];

  always #5 clk = ~clk;

  boreal_biquad_coeff_loader #(
    .NUM_STAGES (N),
    .COEF_W     (CW),
    .SW         (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_stage   (host_stage),
    .host_coef    (host_coef),
    .host_din     (host_din),
    .host_we      (host_we),
    .commit       (commit),
    .err_clr      (err_clr),
    .sample_valid (sample_valid),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .reg_we       (reg_we),
    .stage_sel    (stage_sel),
    .busy         (busy),
    .done         (done),
    .err_overlap  (err_overlap),
    .err_wr_busy  (err_wr_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < N; s++)
      for (int c = 0; c < 5; c++)
        mdl[s][c] = (c == 0) ? 16'h7FFF : 16'h0000;
  endtask

  task automatic host_write(input int s, input int c,
                            input logic [CW-1:0] d);
    host_stage = SW'(s);
    host_coef  = 3'(c);
    host_din   = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    if (s < N && c < 5) mdl[s][c] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  // inj: 0 none, 1 commit, 2 sample_valid, 3 host_we,
  // 4 host_we+err_clr, 5 reset
  task automatic burst(input int inj, input int at);
    int s;
    int c;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int j = 1; j <= NW + 1; j++) begin
      if (j <= NW) begin
        s = (j - 1) / 5;
        c = (j - 1) % 5;
        check("wr_we", reg_we, 1);
        check("wr_addr", reg_addr, c);
        check("wr_din", reg_din, mdl[s][c]);
        check("wr_sel", stage_sel, 1 << s);
        check("wr_done", done, 0);
      end else begin
        check("done", done, 1);
        check("done_we", reg_we, 0);
        check("done_sel", stage_sel, 0);
      end
      check("burst_busy", busy, 1);
      if (j == at + 1 && inj == 2) check("ovl_set", err_overlap, 1);
      if (j == at + 1 && (inj == 3 || inj == 4))
        check("wrb_set", err_wr_busy, 1);
      if (j == at) begin
        case (inj)
          1: commit = 1'b1;
          2: sample_valid = 1'b1;
          3, 4: begin
            host_we    = 1'b1;
            host_stage = 3'($urandom_range(0, N - 1));
            host_coef  = 3'($urandom_range(0, 4));
            host_din   = 16'($urandom);
            err_clr    = (inj == 4);
          end
          5: begin
            rst_n = 1'b0;
            #1;
            check("rst_we", reg_we, 0);
            check("rst_busy", busy, 0);
            check("rst_sel", stage_sel, 0);
            @(negedge clk);
            rst_n = 1'b1;
            mdl_reset();
            return;
          end
          default: ;
        endcase
      end
      @(negedge clk);
      commit       = 1'b0;
      sample_valid = 1'b0;
      host_we      = 1'b0;
      err_clr      = 1'b0;
    end
  endtask

  initial begin
    int nbad;
    int ws;
    int wc;
    logic [CW-1:0] wd;
    mdl_reset();
    repeat (3) @(negedge clk);
    check("rst_reg_we", reg_we, 0);
    check("rst_busy0", busy, 0);
    check("rst_done", done, 0);
    check("rst_stage_sel", stage_sel, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_din", reg_din, 0);
    check("rst_ovl", err_overlap, 0);
    check("rst_wrb", err_wr_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity bank
    do_commit();
    repeat (2) @(negedge clk);
    burst(0, 0);
    check("idle_busy", busy, 0);

    // single directed coefficient
    host_write(2, 3, 16'hC123);
    do_commit();
    burst(0, 0);
    check("idle_busy", busy, 0);

    // random writes, including out-of-range indices
    repeat (16)
      host_write($urandom_range(0, 7), $urandom_range(0, 7),
                 16'($urandom));

    // long wait for a sample boundary
    do_commit();
    nbad = 0;
    repeat (100) begin
      if (busy !== 1'b1 || reg_we !== 1'b0) nbad++;
      @(negedge clk);
    end
    check("hold_wait", nbad, 0);
    burst(0, 0);

    // commit during a burst queues a second burst
    do_commit();
    burst(1, 5);
    check("pend_busy", busy, 1);
    check("pend_we", reg_we, 0);
    check("pend_done", done, 0);
    repeat (3) @(negedge clk);
    check("pend_we2", reg_we, 0);
    burst(0, 0);
    check("idle_busy", busy, 0);

    // sample overlap during the burst
    check("ovl_pre", err_overlap, 0);
    do_commit();
    burst(2, 10);
    check("ovl_sticky", err_overlap, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovl_clr", err_overlap, 0);

    // host write while busy is dropped
    do_commit();
    burst(3, 3);
    check("wrb_sticky", err_wr_busy, 1);
    do_commit();
    burst(0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("wrb_clr", err_wr_busy, 0);

    // write and commit in the same idle cycle
    ws = $urandom_range(0, N - 1);
    wc = $urandom_range(0, 4);
    wd = 16'($urandom);
    host_stage = SW'(ws);
    host_coef  = 3'(wc);
    host_din   = wd;
    host_we    = 1'b1;
    commit     = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    commit  = 1'b0;
    mdl[ws][wc] = wd;
    check("same_cyc_busy", busy, 1);
    check("same_cyc_wrb", err_wr_busy, 0);
    burst(0, 0);

    // set beats clear in the same cycle
    do_commit();
    burst(4, 3);
    check("wrb_set_wins", err_wr_busy, 1);

    // reset in the middle of a burst
    do_commit();
    burst(5, 7);
    check("post_rst_wrb", err_wr_busy, 0);
    check("post_rst_busy", busy, 0);
    do_commit();
    burst(0, 0);
    check("idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
